fetch_redirect_unit: RTL

FETCH_REDIRECT_UNIT -- requirements
Module: fetch_redirect_unit

---
 rtl/fetch_redirect_unit.sv | 90 +++++++++
 1 files changed

// File: rtl/fetch_redirect_unit.sv
// IF-stage PC and IF/ID register with one-bubble taken-branch redirect; pc advances each unstalled cycle.
// Stall holds PC and IF/ID; an accepted branch overrides stall, and the redirect waits in FLUSH while stalled.
module fetch_redirect_unit (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] target_addr,
  input  logic        branch_taken,
  input  logic        stall,
  input  logic [31:0] instr_in,
  output logic [31:0] pc,
  output logic [31:0] ifid_instr,
  output logic [31:0] ifid_pc4,
  output logic        ifid_valid,
  output logic        flushing,
  output logic [15:0] branch_count
);

  typedef enum logic {RUN = 1'b0, FLUSH = 1'b1} state_t;

  state_t      state;
  state_t      stateNext;
  logic [31:0] pcNext;
  logic [31:0] instrNext;
  logic [31:0] pc4Next;
  logic        validNext;
  logic [15:0] countNext;
  logic [31:0] pcPlus4;
  logic        accept;
  logic        unusedTargetLow;

  assign pcPlus4         = pc + 32'd4;
  assign accept          = (state == RUN) && branch_taken && ifid_valid;
  assign flushing        = (state == FLUSH);
  assign unusedTargetLow = ^target_addr[1:0];

  always_comb begin
    stateNext = state;
    pcNext    = pc;
    instrNext = ifid_instr;
    pc4Next   = ifid_pc4;
    validNext = ifid_valid;
    countNext = branch_count;
    case (state)
      RUN: begin
        if (accept) begin
          // Squash the wrong-path instruction already in IF/ID.
          pcNext    = {target_addr[31:2], 2'b00};
          instrNext = 32'h0;
          validNext = 1'b0;
          countNext = (branch_count == 16'hFFFF) ? branch_count : branch_count + 16'd1;
          stateNext = FLUSH;
        end else if (!stall) begin
          pcNext    = pcPlus4;
          instrNext = instr_in;
          pc4Next   = pcPlus4;
          validNext = 1'b1;
        end
      end
      FLUSH: begin
        if (!stall) begin
          pcNext    = pcPlus4;
          instrNext = instr_in;
          pc4Next   = pcPlus4;
          validNext = 1'b1;
          stateNext = RUN;
        end
      end
      default: stateNext = RUN;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state        <= RUN;
      pc           <= 32'h0;
      ifid_instr   <= 32'h0;
      ifid_pc4     <= 32'h0;
      ifid_valid   <= 1'b0;
      branch_count <= 16'h0;
    end else begin
      state        <= stateNext;
      pc           <= pcNext;
      ifid_instr   <= instrNext;
      ifid_pc4     <= pc4Next;
      ifid_valid   <= validNext;
      branch_count <= countNext;
    end
  end

endmodule
